// File: rtl/ieee_mult_arb_pkg.sv
// Shared types and helpers for the shared-multiplier arbiter.
//   id_t / tag_t : requester index and {valid, id} tracking tag, sized for the
//                  default four-requester configuration.
//   rr_next      : round-robin successor of a pointer, wrapping at num_req.
package ieee_mult_arb_pkg;

  localparam int NumReqDefault = 4;
  localparam int IdWidth       = $clog2(NumReqDefault);

  typedef logic [IdWidth-1:0] id_t;

  typedef struct packed {
    logic valid;
    id_t  id;
  } tag_t;

  function automatic int rr_next(input int ptr, input int num_req);
    return (ptr + 1 >= num_req) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/IEEEMult.sv
// Pipelined IEEE 754 single-precision multiplier with a fixed latency.
// Round-to-nearest-even; subnormal inputs and underflowing results flush to a
// signed zero; overflow saturates to infinity; invalid operations give qNaN.
//   clk_i    : clock
//   rst_ni   : synchronous active-low clear of the result pipeline
//   a_i, b_i : operands
//   result_o : product, Latency cycles after the operands
module IEEEMult #(
  parameter int DataWidth = 32,
  parameter int Latency   = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [DataWidth-1:0] a_i,
  input  logic [DataWidth-1:0] b_i,
  output logic [DataWidth-1:0] result_o
);

  localparam int ExpW = 8;
  localparam int ManW = 23;
  localparam int Bias = 127;
  localparam int ExpMax = (1 << ExpW) - 1;

  logic [DataWidth-1:0] prod_c;
  logic [DataWidth-1:0] pipe_q [Latency];

  always_comb begin
    logic              sign, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic [ExpW-1:0]   ea, eb;
    logic [2*ManW+1:0] p;
    logic [ManW-1:0]   frac;
    logic [ManW:0]     frac_r;
    logic              guard, sticky, rnd;
    int                e;

    sign   = a_i[DataWidth-1] ^ b_i[DataWidth-1];
    ea     = a_i[DataWidth-2 -: ExpW];
    eb     = b_i[DataWidth-2 -: ExpW];
    a_zero = (ea == '0);
    b_zero = (eb == '0);
    a_inf  = (ea == '1) && (a_i[ManW-1:0] == '0);
    b_inf  = (eb == '1) && (b_i[ManW-1:0] == '0);
    a_nan  = (ea == '1) && (a_i[ManW-1:0] != '0);
    b_nan  = (eb == '1) && (b_i[ManW-1:0] != '0);

    p = {{(ManW+1){1'b0}}, 1'b1, a_i[ManW-1:0]} * {{(ManW+1){1'b0}}, 1'b1, b_i[ManW-1:0]};
    e = int'(ea) + int'(eb) - Bias;

    // Product of two [1,2) significands lies in [1,4); normalise by one bit.
    if (p[2*ManW+1]) begin
      frac   = p[2*ManW -: ManW];
      guard  = p[ManW];
      sticky = |p[ManW-1:0];
      e      = e + 1;
    end else begin
      frac   = p[2*ManW-1 -: ManW];
      guard  = p[ManW-1];
      sticky = |p[ManW-2:0];
    end

    rnd    = guard & (sticky | frac[0]);
    frac_r = {1'b0, frac} + {{ManW{1'b0}}, rnd};
    // Rounding carried into 2.0: fraction bits are already zero.
    if (frac_r[ManW]) e = e + 1;

    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      prod_c = {1'b0, {ExpW{1'b1}}, 1'b1, {(ManW-1){1'b0}}};
    end else if (a_inf || b_inf || e >= ExpMax) begin
      prod_c = {sign, {ExpW{1'b1}}, {ManW{1'b0}}};
    end else if (a_zero || b_zero || e <= 0) begin
      prod_c = {sign, {(DataWidth-1){1'b0}}};
    end else begin
      prod_c = {sign, ExpW'(e), frac_r[ManW-1:0]};
    end
  end

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples the previous stage's value from before this clock edge.
    if (!rst_ni) begin
      for (int i = 0; i < Latency; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= prod_c;
      for (int i = 1; i < Latency; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign result_o = pipe_q[Latency-1];

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr (with wrap).
//   req       : request vector
//   en        : when low no grant is produced
//   ptr       : highest-priority index for this cycle
//   grant     : one-hot grant (or zero)
//   grant_idx : encoded index of the granted requester (0 when no grant)
module rr_arbiter #(
  parameter  int NumReq  = 4,
  localparam int IdWidth = $clog2(NumReq)
) (
  input  logic [NumReq-1:0]  req,
  input  logic               en,
  input  logic [IdWidth-1:0] ptr,
  output logic [NumReq-1:0]  grant,
  output logic [IdWidth-1:0] grant_idx
);

  always_comb begin
    int   idx;
    logic found;
    // NOTE: every output gets a default before any conditional assignment so
    // no path leaves a value unassigned and no latch is inferred.
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int i = 0; i < NumReq; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NumReq) idx = idx - NumReq;
      if (en && !found && req[IdWidth'(idx)]) begin
        found                  = 1'b1;
        grant[IdWidth'(idx)]   = 1'b1;
        grant_idx              = IdWidth'(idx);
      end
    end
  end

endmodule

// File: rtl/ieee_mult_arbiter.sv
// Shares one pipelined IEEEMult between NumReq requesters.
// A round-robin arbiter issues at most one operation per cycle, only while the
// number of outstanding operations (in flight + buffered) is below FifoDepth,
// so the result FIFO can never overflow. Results return in issue order on one
// tagged valid/ready channel.
//   clk_i, rst_i  : clock, synchronous active-high reset
//   req_valid_i   : per-requester operation valid
//   req_ready_o   : one-hot (or zero) accept, combinational from req_valid_i
//   req_a_i/b_i   : operands per requester
//   resp_valid_o  : result available at FIFO head
//   resp_ready_i  : consumer accepts result
//   resp_id_o     : index of the requester that issued the result
//   resp_result_o : IEEE product
//   busy_o        : any operation in flight or buffered
module ieee_mult_arbiter
  import ieee_mult_arb_pkg::*;
#(
  parameter  int DataWidth = 32,
  parameter  int Latency   = 1,
  parameter  int NumReq    = 4,
  parameter  int FifoDepth = Latency + 2,
  localparam int IdWidth   = $clog2(NumReq)
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [NumReq-1:0]                req_valid_i,
  output logic [NumReq-1:0]                req_ready_o,
  input  logic [NumReq-1:0][DataWidth-1:0] req_a_i,
  input  logic [NumReq-1:0][DataWidth-1:0] req_b_i,
  output logic                             resp_valid_o,
  input  logic                             resp_ready_i,
  output logic [IdWidth-1:0]               resp_id_o,
  output logic [DataWidth-1:0]             resp_result_o,
  output logic                             busy_o
);

  localparam int CntW = $clog2(FifoDepth + 1);
  localparam int PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;

  // Same layout as tag_t, but sized from this instance's NumReq.
  typedef struct packed {
    logic               valid;
    logic [IdWidth-1:0] id;
  } trk_t;

  logic [IdWidth-1:0]   rr_ptr_q;
  logic [CntW-1:0]      outstanding_q;
  logic                 credit, issue, pop, fifo_wr;
  logic [NumReq-1:0]    grant;
  logic [IdWidth-1:0]   grant_idx;
  logic [DataWidth-1:0] mult_a, mult_b, mult_result;
  trk_t                 trk_q [Latency];
  trk_t                 trk_out;
  logic [DataWidth-1:0] fifo_data_q [FifoDepth];
  logic [IdWidth-1:0]   fifo_id_q   [FifoDepth];
  logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]      fifo_cnt_q;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(FifoDepth - 1)) ? '0 : p + 1'b1;
  endfunction

  // ---------------- issue ----------------
  assign credit = (outstanding_q < CntW'(FifoDepth));

  rr_arbiter #(.NumReq(NumReq)) u_arb (
    .req       (req_valid_i),
    .en        (credit && !rst_i),
    .ptr       (rr_ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign issue       = |grant;
  assign req_ready_o = grant;

  // Idle operands are held at zero to keep the multiplier quiet.
  assign mult_a = issue ? req_a_i[grant_idx] : '0;
  assign mult_b = issue ? req_b_i[grant_idx] : '0;

  IEEEMult #(.DataWidth(DataWidth), .Latency(Latency)) u_mult (
    .clk_i    (clk_i),
    .rst_ni   (~rst_i),
    .a_i      (mult_a),
    .b_i      (mult_b),
    .result_o (mult_result)
  );

  // ---------------- tracking ----------------
  // trk_q[Latency-1] lines up with the multiplier output for the same op.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < Latency; i++) trk_q[i] <= '0;
    end else begin
      trk_q[0] <= '{valid: issue, id: grant_idx};
      for (int i = 1; i < Latency; i++) trk_q[i] <= trk_q[i-1];
    end
  end

  assign trk_out = trk_q[Latency-1];
  assign fifo_wr = trk_out.valid;

  // ---------------- result FIFO ----------------
  assign resp_valid_o  = (fifo_cnt_q != '0);
  assign pop           = resp_valid_o && resp_ready_i;
  assign resp_id_o     = fifo_id_q[rd_ptr_q];
  assign resp_result_o = fifo_data_q[rd_ptr_q];

  // NOTE: the storage array is not reset; entries are only ever read after
  // being written, and the pointers/count that qualify them are reset.
  always_ff @(posedge clk_i) begin
    if (fifo_wr && !rst_i) begin
      fifo_data_q[wr_ptr_q] <= mult_result;
      fifo_id_q[wr_ptr_q]   <= trk_out.id;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (fifo_wr) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)     rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({fifo_wr, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + 1'b1;
        2'b01:   fifo_cnt_q <= fifo_cnt_q - 1'b1;
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

  // ---------------- credit and pointer ----------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_q      <= '0;
      outstanding_q <= '0;
    end else begin
      if (issue) rr_ptr_q <= IdWidth'(rr_next(int'(grant_idx), NumReq));
      case ({issue, pop})
        2'b10:   outstanding_q <= outstanding_q + 1'b1;
        2'b01:   outstanding_q <= outstanding_q - 1'b1;
        default: outstanding_q <= outstanding_q;
      endcase
    end
  end

  assign busy_o = (outstanding_q != '0);

  // A write always finds a free slot because every in-flight op holds a credit.
  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    fifo_wr |-> (fifo_cnt_q < CntW'(FifoDepth)));

  a_credit_range: assert property (@(posedge clk_i) disable iff (rst_i)
    outstanding_q <= CntW'(FifoDepth));

endmodule

// File: tb/tb_ieee_mult_arbiter.sv
// Bench for ieee_mult_arbiter: a queue-based model of the arbiter checked every
// cycle on the main instance (Latency=1, FifoDepth=3), directed literal checks,
// and a second instance (Latency=3) for reset while operations are in flight.
module tb_ieee_mult_arbiter;

  localparam int DW    = 32;
  localparam int L     = 1;
  localparam int N     = 4;
  localparam int DEPTH = 3;
  localparam int LB    = 3;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic                 rst_i, rst_b;
  logic [N-1:0]         req_valid, req_valid_b, ready, ready_b;
  logic [N-1:0][DW-1:0] req_a, req_b;
  logic                 resp_ready, resp_ready_b;
  logic                 resp_valid, resp_valid_b;
  logic [1:0]           resp_id, resp_id_b;
  logic [DW-1:0]        resp_result, resp_result_b;
  logic                 busy, busy_b;

  int checks   = 0;
  int failures = 0;

  ieee_mult_arbiter #(.DataWidth(DW), .Latency(L), .NumReq(N), .FifoDepth(DEPTH)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .req_valid_i   (req_valid),
    .req_ready_o   (ready),
    .req_a_i       (req_a),
    .req_b_i       (req_b),
    .resp_valid_o  (resp_valid),
    .resp_ready_i  (resp_ready),
    .resp_id_o     (resp_id),
    .resp_result_o (resp_result),
    .busy_o        (busy)
  );

  ieee_mult_arbiter #(.DataWidth(DW), .Latency(LB), .NumReq(N)) dut_b (
    .clk_i         (clk_i),
    .rst_i         (rst_b),
    .req_valid_i   (req_valid_b),
    .req_ready_o   (ready_b),
    .req_a_i       (req_a),
    .req_b_i       (req_b),
    .resp_valid_o  (resp_valid_b),
    .resp_ready_i  (resp_ready_b),
    .resp_id_o     (resp_id_b),
    .resp_result_o (resp_result_b),
    .busy_o        (busy_b)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Hand-computed float32 products of every operand pair the bench drives.
  function automatic logic [31:0] prod_of(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h40000000, 32'h40400000}: return 32'h40C00000;  //  2.0 *  3.0  =  6.0
      {32'h3FC00000, 32'hC0000000}: return 32'hC0400000;  //  1.5 * -2.0  = -3.0
      {32'h3F800000, 32'h41200000}: return 32'h41200000;  //  1.0 * 10.0  = 10.0
      {32'h40800000, 32'h3E800000}: return 32'h3F800000;  //  4.0 *  0.25 =  1.0
      {32'h3F800001, 32'h3F800001}: return 32'h3F800002;  // (1+u)^2, sticky only
      {32'h80000000, 32'h40400000}: return 32'h80000000;  // -0.0 *  3.0  = -0.0
      default:                      return 32'hxxxxxxxx;
    endcase
  endfunction

  // ---------------- model: issue-ordered queue of outstanding ops ----------------
  typedef struct {
    int          id;
    logic [31:0] prod;
    int          cyc;
  } ent_t;

  ent_t q[$];
  int   m_ptr = 0;
  int   cyc   = 0;

  always @(negedge clk_i) begin
    logic [N-1:0] exp_grant;
    int           g;
    int           j;
    bit           head_vis;
    exp_grant = '0;
    g         = -1;
    j         = 0;
    head_vis  = 1'b0;
    if (rst_i) begin
      check("m_ready_in_reset", 64'(ready), 64'(0));
      q.delete();
      m_ptr = 0;
    end else begin
      head_vis = (q.size() > 0) && (cyc >= q[0].cyc + L + 1);
      if (q.size() < DEPTH) begin
        for (int i = 0; i < N; i++) begin
          j = (m_ptr + i) % N;
          if (g < 0 && req_valid[2'(j)]) g = j;
        end
      end
      if (g >= 0) exp_grant = N'(1) << g;
      check("m_ready", 64'(ready), 64'(exp_grant));
      check("m_resp_valid", 64'(resp_valid), 64'(head_vis));
      if (head_vis) begin
        check("m_resp_id", 64'(resp_id), 64'(q[0].id));
        check("m_resp_result", 64'(resp_result), 64'(q[0].prod));
      end
      check("m_busy", 64'(busy), 64'(q.size() != 0));
      if (head_vis && resp_ready) void'(q.pop_front());
      if (g >= 0) begin
        q.push_back('{id: g, prod: prod_of(req_a[2'(g)], req_b[2'(g)]), cyc: cyc});
        m_ptr = (g + 1) % N;
      end
    end
    cyc++;
  end

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  // ---------------- directed stimulus ----------------
  logic [31:0]  fair_prod [4];
  logic [N-1:0] skip_exp  [3];
  int           accepts, nresp;
  bit           resumed;

  initial begin
    fair_prod = '{32'h40C00000, 32'hC0400000, 32'h41200000, 32'h3F800000};
    skip_exp  = '{4'b1000, 4'b0010, 4'b1000};

    rst_i        = 1'b1;
    rst_b        = 1'b1;
    req_valid    = '0;
    req_valid_b  = '0;
    resp_ready   = 1'b1;
    resp_ready_b = 1'b1;
    req_a[0] = 32'h40000000; req_b[0] = 32'h40400000;
    req_a[1] = 32'h3FC00000; req_b[1] = 32'hC0000000;
    req_a[2] = 32'h3F800000; req_b[2] = 32'h41200000;
    req_a[3] = 32'h40800000; req_b[3] = 32'h3E800000;

    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    #2;
    check("rst_ready", 64'(ready), 64'(0));
    check("rst_resp_valid", 64'(resp_valid), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));

    // Fairness: all four valid for 8 cycles, consumer always ready.
    for (int k = 0; k < 12; k++) begin
      next_cycle();
      req_valid = (k < 8) ? 4'hF : 4'h0;
      #2;
      if (k < 8) check("fair_grant", 64'(ready), 64'(4'b0001 << (k % 4)));
      if (k >= 2 && k < 10) begin
        check("fair_resp_valid", 64'(resp_valid), 64'(1));
        check("fair_resp_id", 64'(resp_id), 64'((k - 2) % 4));
        check("fair_resp_result", 64'(resp_result), 64'(fair_prod[(k - 2) % 4]));
      end else begin
        check("fair_resp_idle", 64'(resp_valid), 64'(0));
      end
    end

    // Single op on req0.
    next_cycle();
    req_valid = 4'b0001;
    #2 check("single_ready", 64'(ready), 64'(4'b0001));
    next_cycle();
    req_valid = 4'b0000;
    #2;
    check("single_busy_t1", 64'(busy), 64'(1));
    check("single_valid_t1", 64'(resp_valid), 64'(0));
    next_cycle();
    #2;
    check("single_valid_t2", 64'(resp_valid), 64'(1));
    check("single_id_t2", 64'(resp_id), 64'(0));
    check("single_result_t2", 64'(resp_result), 64'(32'h40C00000));
    next_cycle();
    #2;
    check("single_busy_t3", 64'(busy), 64'(0));
    check("single_valid_t3", 64'(resp_valid), 64'(0));

    // Backpressure: consumer stalled, req1 always valid.
    accepts = 0;
    for (int k = 0; k < 6; k++) begin
      next_cycle();
      resp_ready = 1'b0;
      req_valid  = 4'b0010;
      #2;
      if (ready == 4'b0010) accepts++;
    end
    check("bp_accepts", 64'(accepts), 64'(3));
    check("bp_ready_blocked", 64'(ready), 64'(0));
    check("bp_busy", 64'(busy), 64'(1));

    nresp   = 0;
    resumed = 1'b0;
    for (int k = 0; k < 8; k++) begin
      next_cycle();
      resp_ready = 1'b1;
      #2;
      if (resp_valid) begin
        nresp++;
        check("bp_resp_id", 64'(resp_id), 64'(1));
        check("bp_resp_result", 64'(resp_result), 64'(32'hC0400000));
      end
      // Outstanding sits at DEPTH-1 with issue and pop together; issue continues.
      if (k == 2 || k == 3) check("bp_issue_at_full_minus1", 64'(ready), 64'(4'b0010));
      if (ready != '0) resumed = 1'b1;
    end
    check("bp_resp_count", 64'(nresp), 64'(8));
    check("bp_resumed", 64'(resumed), 64'(1));

    for (int k = 0; k < 4; k++) begin
      next_cycle();
      req_valid = '0;
    end

    // Pointer skip: pointer is at 2, only req3 and req1 valid.
    req_a[3] = 32'h3F800001;
    req_b[3] = 32'h3F800001;
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      req_valid = 4'b1010;
      #2 check("skip_grant", 64'(ready), 64'(skip_exp[k]));
    end
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      req_valid = '0;
    end

    // Reset mid-flight on the Latency=3 instance.
    req_a[2] = 32'h80000000;
    req_b[2] = 32'h40400000;
    next_cycle();
    rst_b = 1'b0;
    #2;
    check("b_idle_busy", 64'(busy_b), 64'(0));
    check("b_idle_valid", 64'(resp_valid_b), 64'(0));
    next_cycle();
    req_valid_b = 4'b0011;
    #2 check("b_grant0", 64'(ready_b), 64'(4'b0001));
    next_cycle();
    #2 check("b_grant1", 64'(ready_b), 64'(4'b0010));
    next_cycle();
    req_valid_b = 4'b0000;
    rst_b       = 1'b1;
    #2;
    check("b_reset_ready", 64'(ready_b), 64'(0));
    check("b_busy_before_reset", 64'(busy_b), 64'(1));
    next_cycle();
    rst_b       = 1'b0;
    req_valid_b = 4'b1111;
    #2;
    check("b_post_reset_busy", 64'(busy_b), 64'(0));
    check("b_post_reset_valid", 64'(resp_valid_b), 64'(0));
    check("b_post_reset_ptr", 64'(ready_b), 64'(4'b0001));
    req_valid_b = 4'b0100;
    #1 check("b_req2_grant", 64'(ready_b), 64'(4'b0100));
    for (int m = 0; m < 9; m++) begin
      next_cycle();
      req_valid_b = '0;
      #2;
      if (m == 3) begin
        check("b_new_valid", 64'(resp_valid_b), 64'(1));
        check("b_new_id", 64'(resp_id_b), 64'(2));
        check("b_new_result", 64'(resp_result_b), 64'(32'h80000000));
      end else begin
        check("b_no_stale_resp", 64'(resp_valid_b), 64'(0));
      end
      if (m == 0) check("b_busy_new_op", 64'(busy_b), 64'(1));
    end
    check("b_final_busy", 64'(busy_b), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
